// File: rtl/dma_xfer_timing.sv
`default_nettype none
// ============================================================================
// Module   : dma_xfer_timing
// Purpose  : Single-channel DMA transfer timing state machine. Arbitrates the
//            bus with the CPU (HRQ/HLDA), services the device handshake
//            (DREQ/DACK), sequences address, bus strobes and the data-buffer
//            controls (MemToMem/MEMRW), owns the current address/count
//            registers and reports terminal count.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock
//   RESET      in   asynchronous active-high reset
//   cfg_load   in   load current regs from base values, clear TC (IDLE only)
//   base_src   in   start address (I/O modes) / source address (mem-to-mem)
//   base_dst   in   destination address (mem-to-mem)
//   base_cnt   in   word count, number of transfers = base_cnt + 1
//   xfer_type  in   01 I/O->mem, 10 mem->I/O, 11 mem-to-mem, 00 verify
//   addr_dec   in   1: addresses decrement, 0: increment
//   autoinit   in   reload current regs from base values at terminal count
//   sw_req     in   software request pulse (mem-to-mem start)
//   DREQ       in   device request
//   HLDA       in   CPU hold acknowledge
//   EOP_in_n   in   external end-of-process, active-low
//   HRQ        out  hold request to CPU
//   DACK       out  device acknowledge
//   AEN        out  address enable
//   addr_out   out  current bus address
//   MEMR_n/MEMW_n/IOR_n/IOW_n out  bus strobes, active-low
//   MemToMem   out  data buffer in mem-to-mem operation
//   MEMRW      out  data buffer phase: 0 latch, 1 drive
//   EOP_n      out  terminal-count pulse, active-low
//   TC         out  sticky done flag
//   busy       out  state machine not idle
// ============================================================================
module dma_xfer_timing #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              cfg_load,
  input  logic [ADDR_W-1:0] base_src,
  input  logic [ADDR_W-1:0] base_dst,
  input  logic [CNT_W-1:0]  base_cnt,
  input  logic [1:0]        xfer_type,
  input  logic              addr_dec,
  input  logic              autoinit,
  input  logic              sw_req,
  input  logic              DREQ,
  input  logic              HLDA,
  input  logic              EOP_in_n,
  output logic              HRQ,
  output logic              DACK,
  output logic              AEN,
  output logic [ADDR_W-1:0] addr_out,
  output logic              MEMR_n,
  output logic              MEMW_n,
  output logic              IOR_n,
  output logic              IOW_n,
  output logic              MemToMem,
  output logic              MEMRW,
  output logic              EOP_n,
  output logic              TC,
  output logic              busy
);

  localparam logic [1:0]        C_MODE_IO2MEM = 2'b01;
  localparam logic [1:0]        C_MODE_MEM2IO = 2'b10;
  localparam logic [1:0]        C_MODE_M2M    = 2'b11;
  localparam logic [ADDR_W-1:0] C_ADDR_ONE    = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  C_CNT_ZERO    = '0;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_REQ  = 4'd1,
    ST_S1   = 4'd2,
    ST_S2   = 4'd3,
    ST_S3   = 4'd4,
    ST_S4   = 4'd5,
    ST_R1   = 4'd6,
    ST_R2   = 4'd7,
    ST_R3   = 4'd8,
    ST_R4   = 4'd9,
    ST_W1   = 4'd10,
    ST_W2   = 4'd11,
    ST_W3   = 4'd12,
    ST_W4   = 4'd13
  } state_t;

  // Registered state
  state_t            r_state;
  logic [1:0]        r_mode;      // transfer type captured when the request is accepted
  logic [ADDR_W-1:0] r_cur_src;
  logic [ADDR_W-1:0] r_cur_dst;
  logic [CNT_W-1:0]  r_cur_cnt;
  logic              r_eop_seen;  // external EOP observed during the current transfer
  logic              r_term;      // current transfer is the terminal one

  // Next-state values
  state_t            w_state_nxt;
  logic [1:0]        w_mode_nxt;
  logic [ADDR_W-1:0] w_src_nxt;
  logic [ADDR_W-1:0] w_dst_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_eop_seen_nxt;
  logic              w_term_nxt;
  logic              w_tc_nxt;

  logic [ADDR_W-1:0] w_src_step;
  logic [ADDR_W-1:0] w_dst_step;
  logic [CNT_W-1:0]  w_cnt_dec;

  // Next-state classification, used to build the registered outputs
  logic w_nxt_s;
  logic w_nxt_r;
  logic w_nxt_w;
  logic w_nxt_s_mid;
  logic w_nxt_r_mid;
  logic w_nxt_w_mid;

  assign w_src_step = addr_dec ? (r_cur_src - C_ADDR_ONE) : (r_cur_src + C_ADDR_ONE);
  assign w_dst_step = addr_dec ? (r_cur_dst - C_ADDR_ONE) : (r_cur_dst + C_ADDR_ONE);
  assign w_cnt_dec  = r_cur_cnt - C_CNT_ONE;

  always_comb begin
    w_state_nxt    = r_state;
    w_mode_nxt     = r_mode;
    w_src_nxt      = r_cur_src;
    w_dst_nxt      = r_cur_dst;
    w_cnt_nxt      = r_cur_cnt;
    w_eop_seen_nxt = r_eop_seen;
    w_term_nxt     = r_term;
    w_tc_nxt       = TC;

    case (r_state)
      ST_IDLE: begin
        if (cfg_load) begin
          w_src_nxt = base_src;
          w_dst_nxt = base_dst;
          w_cnt_nxt = base_cnt;
          w_tc_nxt  = 1'b0;
        end
        // Request acceptance looks at the flag as it stands this cycle
        if (!TC) begin
          if (xfer_type == C_MODE_M2M) begin
            if (sw_req) begin
              w_state_nxt = ST_REQ;
              w_mode_nxt  = xfer_type;
            end
          end else if (DREQ) begin
            w_state_nxt = ST_REQ;
            w_mode_nxt  = xfer_type;
          end
        end
      end

      ST_REQ: begin
        if (HLDA) begin
          w_state_nxt = (r_mode == C_MODE_M2M) ? ST_R1 : ST_S1;
        end else if ((r_mode != C_MODE_M2M) && !DREQ) begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_S1: begin
        w_state_nxt    = ST_S2;
        w_eop_seen_nxt = 1'b0;
      end

      ST_S2: begin
        w_state_nxt    = ST_S3;
        w_eop_seen_nxt = r_eop_seen | ~EOP_in_n;
      end

      // Terminal decision is made on entry to S4 so EOP_n can be registered
      ST_S3: begin
        w_state_nxt    = ST_S4;
        w_eop_seen_nxt = r_eop_seen | ~EOP_in_n;
        w_term_nxt     = (r_cur_cnt == C_CNT_ZERO) | r_eop_seen | ~EOP_in_n;
      end

      ST_S4: begin
        w_src_nxt = w_src_step;
        w_cnt_nxt = w_cnt_dec;
        if (r_term) begin
          w_state_nxt = ST_IDLE;
          if (autoinit) begin
            w_src_nxt = base_src;
            w_dst_nxt = base_dst;
            w_cnt_nxt = base_cnt;
          end else begin
            w_tc_nxt = 1'b1;
          end
        end else if (DREQ && HLDA) begin
          w_state_nxt = ST_S1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_R1: begin
        w_state_nxt    = ST_R2;
        w_eop_seen_nxt = 1'b0;
      end

      ST_R2: begin
        w_state_nxt    = ST_R3;
        w_eop_seen_nxt = r_eop_seen | ~EOP_in_n;
      end

      ST_R3: begin
        w_state_nxt    = ST_R4;
        w_eop_seen_nxt = r_eop_seen | ~EOP_in_n;
      end

      ST_R4: begin
        w_state_nxt    = ST_W1;
        w_src_nxt      = w_src_step;
        w_eop_seen_nxt = r_eop_seen | ~EOP_in_n;
      end

      ST_W1: begin
        w_state_nxt    = ST_W2;
        w_eop_seen_nxt = r_eop_seen | ~EOP_in_n;
      end

      ST_W2: begin
        w_state_nxt    = ST_W3;
        w_eop_seen_nxt = r_eop_seen | ~EOP_in_n;
      end

      ST_W3: begin
        w_state_nxt    = ST_W4;
        w_eop_seen_nxt = r_eop_seen | ~EOP_in_n;
        w_term_nxt     = (r_cur_cnt == C_CNT_ZERO) | r_eop_seen | ~EOP_in_n;
      end

      ST_W4: begin
        w_dst_nxt = w_dst_step;
        w_cnt_nxt = w_cnt_dec;
        if (r_term) begin
          w_state_nxt = ST_IDLE;
          if (autoinit) begin
            w_src_nxt = base_src;
            w_dst_nxt = base_dst;
            w_cnt_nxt = base_cnt;
          end else begin
            w_tc_nxt = 1'b1;
          end
        end else if (HLDA) begin
          w_state_nxt = ST_R1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_nxt_s     = (w_state_nxt == ST_S1) || (w_state_nxt == ST_S2) ||
                       (w_state_nxt == ST_S3) || (w_state_nxt == ST_S4);
  assign w_nxt_r     = (w_state_nxt == ST_R1) || (w_state_nxt == ST_R2) ||
                       (w_state_nxt == ST_R3) || (w_state_nxt == ST_R4);
  assign w_nxt_w     = (w_state_nxt == ST_W1) || (w_state_nxt == ST_W2) ||
                       (w_state_nxt == ST_W3) || (w_state_nxt == ST_W4);
  assign w_nxt_s_mid = (w_state_nxt == ST_S2) || (w_state_nxt == ST_S3);
  assign w_nxt_r_mid = (w_state_nxt == ST_R2) || (w_state_nxt == ST_R3);
  assign w_nxt_w_mid = (w_state_nxt == ST_W2) || (w_state_nxt == ST_W3);

  // State, datapath and all outputs are registered together; outputs are
  // decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_mode     <= 2'b00;
      r_cur_src  <= '0;
      r_cur_dst  <= '0;
      r_cur_cnt  <= '0;
      r_eop_seen <= 1'b0;
      r_term     <= 1'b0;
      HRQ        <= 1'b0;
      DACK       <= 1'b0;
      AEN        <= 1'b0;
      addr_out   <= '0;
      MEMR_n     <= 1'b1;
      MEMW_n     <= 1'b1;
      IOR_n      <= 1'b1;
      IOW_n      <= 1'b1;
      MemToMem   <= 1'b0;
      MEMRW      <= 1'b0;
      EOP_n      <= 1'b1;
      TC         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_cur_src  <= w_src_nxt;
      r_cur_dst  <= w_dst_nxt;
      r_cur_cnt  <= w_cnt_nxt;
      r_eop_seen <= w_eop_seen_nxt;
      r_term     <= w_term_nxt;
      TC         <= w_tc_nxt;

      HRQ  <= (w_state_nxt != ST_IDLE);
      busy <= (w_state_nxt != ST_IDLE);
      AEN  <= w_nxt_s | w_nxt_r | w_nxt_w;
      DACK <= w_nxt_s;

      // Address holds its last value outside the transfer states
      if (w_nxt_s || w_nxt_r) begin
        addr_out <= w_src_nxt;
      end else if (w_nxt_w) begin
        addr_out <= w_dst_nxt;
      end

      MEMR_n   <= ~((w_nxt_s_mid && (w_mode_nxt == C_MODE_MEM2IO)) || w_nxt_r_mid);
      MEMW_n   <= ~((w_nxt_s_mid && (w_mode_nxt == C_MODE_IO2MEM)) || w_nxt_w_mid);
      IOR_n    <= ~(w_nxt_s_mid && (w_mode_nxt == C_MODE_IO2MEM));
      IOW_n    <= ~(w_nxt_s_mid && (w_mode_nxt == C_MODE_MEM2IO));
      // Buffer latches on the R3->R4 edge, then drives for the whole write half
      MemToMem <= (w_state_nxt == ST_R3) || w_nxt_w;
      MEMRW    <= w_nxt_w;
      EOP_n    <= ~(((w_state_nxt == ST_S4) || (w_state_nxt == ST_W4)) && w_term_nxt);
    end
  end

endmodule
`default_nettype wire
